card_draw_data_path: RTL and testbench
======================================

Name: card_draw_data_path

Overview:
- Datapath stage directly downstream of the seed_random control path.
- Consumes the control path's IDLE/SEND state (0/1). On each IDLE->SEND transition it draws one not-yet-dealt card from a 52-card deck.
- Card selection uses a free-running LFSR plus linear probing. Result goes to the game FSM as index, rank and blackjack points, with a one-cycle valid pulse.
- Tracks dealt cards with a 52-bit mask and supports reshuffle.

Parameters:
- LFSR_W, 16, LFSR width; fixed taps x^16+x^14+x^13+x^11+1 (Fibonacci, shift left, feedback into bit 0).
- SEED, 16'hACE1, LFSR reset value; if 0, reset loads 16'h0001 instead.

Ports:
- clk_dp_i  in  1  clock, rising edge.
- rst_dp_i  in  1  reset, asynchronous, active-low.
- state_i  in  1  control-path state (0=IDLE, 1=SEND).
- shuffle_i  in  1  synchronous; clears dealt mask, aborts any draw.
- card_idx_o  out  6  dealt card index 0..51.
- card_rank_o  out  4  rank 1..13 = (idx mod 13)+1.
- card_points_o  out  4  rank 1 -> 11; ranks 2..10 -> rank; ranks 11..13 -> 10.
- card_valid_o  out  1  one-cycle pulse, card outputs valid.
- busy_o  out  1  high in PICK/PROBE.
- cards_left_o  out  6  undealt count, 52..0.
- deck_empty_o  out  1  cards_left_o==0.

Behaviour:
- Reset values:
  - card_idx_o=0, card_rank_o=0, card_points_o=0.
  - card_valid_o=0, busy_o=0.
  - cards_left_o=52, deck_empty_o=0.
  - mask=0, lfsr=SEED (or 1 if SEED is 0), state_q=0, FSM=IDLE.
- LFSR: advances every cycle, including during a draw; never reaches zero.
- Edge detect: state_q<=state_i every cycle. start = state_i & ~state_q & FSM==IDLE & ~deck_empty & ~shuffle_i.
- FSM states: IDLE, PICK, PROBE, DONE.
  - IDLE: on start, capture raw=lfsr[5:0]; cand = raw>=52 ? raw-52 : raw; go to PICK.
  - PICK/PROBE: if mask[cand]==0, go to DONE. Otherwise cand = (cand==51) ? 0 : cand+1 and go to PROBE. At most 51 probes are guaranteed, because a draw only starts when at least one card is undealt.
  - DONE (single cycle):
    - set mask[cand];
    - cards_left--;
    - register idx/rank/points;
    - card_valid_o=1 for exactly this cycle;
    - next state IDLE.
- Latency: edge seen at cycle N -> card_valid_o at N+2 if the first candidate is free; +1 cycle per collision. Worst case N+53.
- Card outputs hold their last value between draws.
- Boundary conditions:
  - Rising edge while not IDLE: ignored, never queued.
  - SEND held high: only one draw per IDLE->SEND transition.
  - Request while deck_empty: ignored; no valid pulse; outputs unchanged.
  - shuffle_i in any state: next cycle mask=0, cards_left=52, FSM=IDLE, no valid pulse for the aborted draw. Simultaneous with an edge, shuffle wins and the request is dropped.
  - shuffle_i in the DONE cycle: the valid pulse still occurs that cycle, but the mask/count update is overridden by shuffle.
  - Reset asserted mid-draw: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro SEED_LOAD_EN.
- Defined:
  - adds ports seed_i (in, LFSR_W) and seed_load_i (in, 1);
  - when seed_load_i=1, lfsr <= seed_i (seed 0 loads 1), replacing that cycle's shift;
  - draws in progress are unaffected, except that later candidates use the new sequence.
- Undefined: ports absent; LFSR free-runs from SEED only.

Decomposition:
- Shared package seed_random_pkg:
  - state encodings IDLE_ST=0 / SEND_ST=1, shared with the control path;
  - DECK_SIZE=52, RANKS=13;
  - LFSR tap constant;
  - FSM state typedef/localparams.
- One natural sub-module: card_lfsr. Holds the LFSR register, taps, zero guard and the optional seed load; output is the current value.
- Edge detect, FSM, mask, probe and rank/points mapping stay in the top.

Test Plan:
- Reset release -> cards_left_o=52, deck_empty_o=0, card_valid_o=0, busy_o=0. Single IDLE->SEND -> exactly one valid pulse at edge+2 (empty deck, no collision); cards_left_o=51; idx matches bench LFSR model folded mod 52.
- 52 request edges separated by IDLE -> 52 unique indices 0..51; cards_left_o reaches 0; deck_empty_o=1. 53rd edge -> no valid, busy_o stays 0.
- SEED_LOAD_EN, seed_load_i with seed_i=16'h0000 -> lfsr=16'h0001. Rank/points mapping checked for idx 0/12/13/9 -> (1,11)/(13,10)/(1,11)/(10,10).
- Draw 51 cards, then request -> latency = 2 + collisions, matching the model. Final card equals the single cleared mask bit.
- shuffle_i during PROBE -> no valid pulse, cards_left_o=52 next cycle. Shuffle coincident with SEND edge -> request dropped.
- state_i held SEND 100 cycles -> one draw only. Async reset mid-PROBE -> outputs at reset values in the same cycle, no valid pulse.

Source files
------------

// File: rtl/seed_random_pkg.sv
// rtl/seed_random_pkg.sv - shared constants, FSM encodings and card mapping helpers
//
// Purpose : definitions shared by the seed_random control path and the
//           card draw datapath (state encodings, deck geometry, LFSR taps,
//           draw FSM states, rank/points mapping).
// Ports   : none (package).
package seed_random_pkg;

  // Control-path state encoding, as seen on card_draw_data_path.state_i
  localparam logic IDLE_ST = 1'b0;
  localparam logic SEND_ST = 1'b1;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] fsm_t;
  localparam fsm_t FSM_IDLE  = 2'd0;
  localparam fsm_t FSM_PICK  = 2'd1;
  localparam fsm_t FSM_PROBE = 2'd2;
  localparam fsm_t FSM_DONE  = 2'd3;

  // rank 1..13 = (idx mod 13) + 1, idx limited to 0..51
  function automatic logic [3:0] card_rank(input logic [5:0] idx);
    logic [5:0] r;
    r = idx;
    if (r >= 6'(3 * RANKS))      r = r - 6'(3 * RANKS);
    else if (r >= 6'(2 * RANKS)) r = r - 6'(2 * RANKS);
    else if (r >= 6'(RANKS))     r = r - 6'(RANKS);
    return r[3:0] + 4'd1;
  endfunction

  // ace counts 11, face cards 10, others their rank
  function automatic logic [3:0] card_points(input logic [3:0] rank);
    if (rank == 4'd1)       return 4'd11;
    else if (rank > 4'd10)  return 4'd10;
    else                    return rank;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - free-running 16-bit Fibonacci LFSR with zero guard
//
// Purpose : pseudo-random source for card selection; advances every cycle.
//           Optional macro SEED_LOAD_EN adds a synchronous seed load.
// Ports   : clk_dp_i    in  clock, rising edge
//           rst_dp_i    in  asynchronous active-low reset (loads SEED, 0 -> 1)
//           seed_i      in  seed value           (SEED_LOAD_EN only)
//           seed_load_i in  load seed this cycle (SEED_LOAD_EN only)
//           lfsr_o      out current LFSR value
module card_lfsr
  import seed_random_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk_dp_i,
  input  logic              rst_dp_i,
`ifdef SEED_LOAD_EN
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_load_i,
`endif
  output logic [LFSR_W-1:0] lfsr_o
);

  // an all-zero state would lock the LFSR, so zero seeds become 1
  localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic              feedback;

  assign feedback = ^(lfsr_q & LFSR_W'(LFSR_TAPS));

  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      lfsr_q <= RESET_VAL;
`ifdef SEED_LOAD_EN
    end else if (seed_load_i) begin
      lfsr_q <= (seed_i == '0) ? LFSR_W'(1) : seed_i;
`endif
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], feedback};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/card_draw_data_path.sv
// rtl/card_draw_data_path.sv - draws one undealt card per IDLE->SEND transition
//
// Purpose : edge-detects the control-path state, picks a card from the LFSR
//           with linear probing over a 52-bit dealt mask, reports index,
//           rank and blackjack points with a one-cycle valid pulse.
//           Optional macro SEED_LOAD_EN adds seed_i / seed_load_i.
// Ports   : clk_dp_i      in  clock, rising edge
//           rst_dp_i      in  asynchronous active-low reset
//           state_i       in  control-path state (0=IDLE, 1=SEND)
//           shuffle_i     in  clear dealt mask, abort any draw
//           seed_i        in  LFSR seed           (SEED_LOAD_EN only)
//           seed_load_i   in  load seed this cycle (SEED_LOAD_EN only)
//           card_idx_o    out dealt card index 0..51
//           card_rank_o   out rank 1..13
//           card_points_o out blackjack points
//           card_valid_o  out one-cycle pulse, card outputs valid
//           busy_o        out draw in progress (PICK/PROBE)
//           cards_left_o  out undealt card count
//           deck_empty_o  out no cards left
module card_draw_data_path
  import seed_random_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk_dp_i,
  input  logic              rst_dp_i,
  input  logic              state_i,
  input  logic              shuffle_i,
`ifdef SEED_LOAD_EN
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_load_i,
`endif
  output logic [5:0]        card_idx_o,
  output logic [3:0]        card_rank_o,
  output logic [3:0]        card_points_o,
  output logic              card_valid_o,
  output logic              busy_o,
  output logic [5:0]        cards_left_o,
  output logic              deck_empty_o
);

  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_unused;
  logic                 state_q;
  fsm_t                 fsm_q;
  logic [5:0]           cand_q;
  logic [DECK_SIZE-1:0] mask_q;
  logic [5:0]           left_q;
  logic [5:0]           idx_q;
  logic [3:0]           rank_q;
  logic [3:0]           points_q;
  logic                 valid_q;
  logic [5:0]           raw;
  logic [5:0]           first_cand;
  logic                 start;

  card_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk_dp_i    (clk_dp_i),
    .rst_dp_i    (rst_dp_i),
`ifdef SEED_LOAD_EN
    .seed_i      (seed_i),
    .seed_load_i (seed_load_i),
`endif
    .lfsr_o      (lfsr)
  );

  // only the low six bits pick a card; the rest just keep the sequence long
  assign lfsr_unused = ^lfsr[LFSR_W-1:6];

  assign raw        = lfsr[5:0];
  assign first_cand = (raw >= 6'(DECK_SIZE)) ? raw - 6'(DECK_SIZE) : raw;

  assign deck_empty_o = (left_q == 6'd0);

  // edges outside IDLE are dropped, not queued
  assign start = (state_i == SEND_ST) && (state_q == IDLE_ST) &&
                 (fsm_q == FSM_IDLE) && !deck_empty_o && !shuffle_i;

  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      state_q  <= IDLE_ST;
      fsm_q    <= FSM_IDLE;
      cand_q   <= 6'd0;
      mask_q   <= '0;
      left_q   <= 6'(DECK_SIZE);
      idx_q    <= 6'd0;
      rank_q   <= 4'd0;
      points_q <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_i;
      valid_q <= 1'b0;
      case (fsm_q)
        FSM_IDLE: begin
          if (start) begin
            cand_q <= first_cand;
            fsm_q  <= FSM_PICK;
          end
        end
        FSM_PICK, FSM_PROBE: begin
          // terminates: a draw only starts with at least one free card
          if (!mask_q[cand_q]) begin
            fsm_q <= FSM_DONE;
          end else begin
            cand_q <= (cand_q == 6'(DECK_SIZE - 1)) ? 6'd0 : cand_q + 6'd1;
            fsm_q  <= FSM_PROBE;
          end
        end
        FSM_DONE: begin
          mask_q[cand_q] <= 1'b1;
          left_q         <= left_q - 6'd1;
          idx_q          <= cand_q;
          rank_q         <= card_rank(cand_q);
          points_q       <= card_points(card_rank(cand_q));
          valid_q        <= 1'b1;
          fsm_q          <= FSM_IDLE;
        end
        default: fsm_q <= FSM_IDLE;
      endcase
      // shuffle overrides mask/count/FSM but leaves a DONE-cycle pulse intact
      if (shuffle_i) begin
        mask_q <= '0;
        left_q <= 6'(DECK_SIZE);
        fsm_q  <= FSM_IDLE;
      end
    end
  end

  assign card_idx_o    = idx_q;
  assign card_rank_o   = rank_q;
  assign card_points_o = points_q;
  assign card_valid_o  = valid_q;
  assign busy_o        = (fsm_q == FSM_PICK) || (fsm_q == FSM_PROBE);
  assign cards_left_o  = left_q;

endmodule

// File: tb/tb_card_draw_data_path.sv
// tb/tb_card_draw_data_path.sv - scoreboard bench for card_draw_data_path
module tb_card_draw_data_path;

  logic        clk = 1'b0;
  logic        rst_dp_i;
  logic        state_i;
  logic        shuffle_i;
  logic [15:0] seed_i;
  logic        seed_load_i;
  logic [5:0]  card_idx_o;
  logic [3:0]  card_rank_o;
  logic [3:0]  card_points_o;
  logic        card_valid_o;
  logic        busy_o;
  logic [5:0]  cards_left_o;
  logic        deck_empty_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_lfsr;
  logic [51:0] dealt;
  int          exp_idx_q[$];
  int          exp_lat_q[$];

  always #5 clk = ~clk;

  card_draw_data_path #(
    .LFSR_W (16),
    .SEED   (16'hACE1)
  ) dut (
    .clk_dp_i      (clk),
    .rst_dp_i      (rst_dp_i),
    .state_i       (state_i),
    .shuffle_i     (shuffle_i),
`ifdef SEED_LOAD_EN
    .seed_i        (seed_i),
    .seed_load_i   (seed_load_i),
`endif
    .card_idx_o    (card_idx_o),
    .card_rank_o   (card_rank_o),
    .card_points_o (card_points_o),
    .card_valid_o  (card_valid_o),
    .busy_o        (busy_o),
    .cards_left_o  (cards_left_o),
    .deck_empty_o  (deck_empty_o)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // reference LFSR: free-running from ACE1, optional seed load
  always @(posedge clk or negedge rst_dp_i) begin
    if (!rst_dp_i)         model_lfsr <= 16'hACE1;
    else if (seed_load_i)  model_lfsr <= (seed_i == 16'h0) ? 16'h0001 : seed_i;
    else                   model_lfsr <= lfsr_next(model_lfsr);
  end

  function automatic int fold_cand();
    int c;
    c = int'(model_lfsr[5:0]);
    if (c >= 52) c = c - 52;
    return c;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // called at a negedge with FSM idle and state_q low; returns at a negedge
  task automatic draw_card(input bit release_send);
    int  cand, coll, lat, e_idx, e_lat, rank, pts;
    bit  seen;
    cand = fold_cand();
    coll = 0;
    while (dealt[cand]) begin
      cand = (cand == 51) ? 0 : cand + 1;
      coll++;
    end
    exp_idx_q.push_back(cand);
    exp_lat_q.push_back(3 + coll);
    dealt[cand] = 1'b1;
    state_i = 1'b1;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 70) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_in_draw", busy_o, 1);
      if (card_valid_o) seen = 1;
    end
    check("draw_seen", seen, 1);
    e_idx = exp_idx_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    if (seen) begin
      rank = (e_idx % 13) + 1;
      pts  = (rank == 1) ? 11 : ((rank > 10) ? 10 : rank);
      check("idx", card_idx_o, e_idx);
      check("rank", card_rank_o, rank);
      check("points", card_points_o, pts);
      check("latency", lat, e_lat);
      check("cards_left", cards_left_o, 52 - $countones(dealt));
    end
    if (release_send) state_i = 1'b0;
    @(negedge clk);
    check("valid_width", card_valid_o, 0);
  endtask

  task automatic wait_collision(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (dealt[fold_cand()]) ok = 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    int  pulses, busy_seen;
    bit  ok;
    logic [5:0] last_idx;

    rst_dp_i    = 1'b0;
    state_i     = 1'b0;
    shuffle_i   = 1'b0;
    seed_i      = 16'h0;
    seed_load_i = 1'b0;
    dealt       = '0;
    repeat (3) @(negedge clk);
    rst_dp_i = 1'b1;
    @(negedge clk);

    check("rst_cards_left", cards_left_o, 52);
    check("rst_deck_empty", deck_empty_o, 0);
    check("rst_valid", card_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_idx", card_idx_o, 0);

    // whole deck: 52 unique cards, probing grows toward the end
    for (int n = 0; n < 52; n++) draw_card(1'b1);
    check("full_deal_mask", $countones(dealt), 52);
    check("empty_left", cards_left_o, 0);
    check("empty_flag", deck_empty_o, 1);

    // request on empty deck is ignored
    last_idx  = card_idx_o;
    pulses    = 0;
    busy_seen = 0;
    state_i   = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (card_valid_o) pulses++;
      if (busy_o) busy_seen++;
    end
    state_i = 1'b0;
    @(negedge clk);
    check("empty_no_valid", pulses, 0);
    check("empty_no_busy", busy_seen, 0);
    check("empty_idx_hold", card_idx_o, last_idx);

    // shuffle restores the deck
    shuffle_i = 1'b1;
    @(negedge clk);
    shuffle_i = 1'b0;
    dealt = '0;
    check("shuffle_left", cards_left_o, 52);
    check("shuffle_empty", deck_empty_o, 0);

    // partial deal, then shuffle during probing aborts the draw
    for (int n = 0; n < 30; n++) draw_card(1'b1);
    wait_collision(ok);
    check("collision_found", ok, 1);
    state_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("probe_busy", busy_o, 1);
    shuffle_i = 1'b1;
    @(negedge clk);
    shuffle_i = 1'b0;
    dealt = '0;
    check("abort_left", cards_left_o, 52);
    check("abort_busy", busy_o, 0);
    pulses = card_valid_o;
    repeat (5) begin
      @(negedge clk);
      if (card_valid_o) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    state_i = 1'b0;
    @(negedge clk);

    // shuffle coincident with the SEND edge drops the request
    draw_card(1'b1);
    draw_card(1'b1);
    state_i   = 1'b1;
    shuffle_i = 1'b1;
    @(negedge clk);
    shuffle_i = 1'b0;
    dealt = '0;
    check("coinc_busy", busy_o, 0);
    check("coinc_left", cards_left_o, 52);
    pulses = card_valid_o;
    repeat (5) begin
      @(negedge clk);
      if (card_valid_o) pulses++;
    end
    check("coinc_no_valid", pulses, 0);
    state_i = 1'b0;
    @(negedge clk);

    // SEND held for 100 cycles gives a single draw
    draw_card(1'b0);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (card_valid_o) pulses++;
    end
    check("held_send_one_draw", pulses, 0);
    check("held_left", cards_left_o, 51);
    state_i = 1'b0;
    @(negedge clk);

    // asynchronous reset while probing
    for (int n = 0; n < 20; n++) draw_card(1'b1);
    wait_collision(ok);
    check("collision_found2", ok, 1);
    state_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("probe_busy2", busy_o, 1);
    rst_dp_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", card_valid_o, 0);
    check("arst_left", cards_left_o, 52);
    check("arst_idx", card_idx_o, 0);
    check("arst_rank", card_rank_o, 0);
    check("arst_points", card_points_o, 0);
    state_i = 1'b0;
    dealt   = '0;
    @(negedge clk);
    check("arst_hold_valid", card_valid_o, 0);
    rst_dp_i = 1'b1;
    @(negedge clk);
    draw_card(1'b1);

`ifdef SEED_LOAD_EN
    // zero seed loads 1, so the next candidate is card 1 on a fresh deck
    shuffle_i = 1'b1;
    @(negedge clk);
    shuffle_i   = 1'b0;
    dealt       = '0;
    seed_i      = 16'h0000;
    seed_load_i = 1'b1;
    @(negedge clk);
    seed_load_i = 1'b0;
    draw_card(1'b1);
    check("seed0_idx", card_idx_o, 1);
    check("seed0_rank", card_rank_o, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
